// File: rtl/board_press_classifier.sv
// Classifies debounced button gestures into one-cycle short, double, long and auto-repeat pulses.
// All outputs are registered; busy reports that a gesture is in progress.
module board_press_classifier #(
    parameter int unsigned CW         = 26,
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned DOUBLE_CYC = 15_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic db_level,
    output logic short_tick,
    output logic double_tick,
    output logic long_tick,
    output logic repeat_tick,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HELD   = 3'd4
    } state_t;

    localparam logic [CW-1:0] LONG_TC   = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] DOUBLE_TC = CW'(DOUBLE_CYC - 1);
    localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_lvl_q;
    logic          r_short;
    logic          r_double;
    logic          r_long;
    logic          r_repeat;
    logic          r_busy;
    logic          w_rise;
    logic          w_short;
    logic          w_double;
    logic          w_long;
    logic          w_repeat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_lvl_q  <= 1'b1;
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_lvl_q  <= db_level;
            r_short  <= w_short;
            r_double <= w_double;
            r_long   <= w_long;
            r_repeat <= w_repeat;
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    // Release and second-rise checks come before terminal counts so they win on a tie.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_short     = 1'b0;
        w_double    = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        w_rise      = db_level & ~r_lvl_q;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = PRESS1;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS1: begin
                if (!db_level) begin
                    w_state_nxt = WAIT2;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LONG_TC) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_long      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            WAIT2: begin
                if (w_rise) begin
                    w_state_nxt = PRESS2;
                    w_cnt_nxt   = '0;
                    w_double    = 1'b1;
                end else if (r_cnt == DOUBLE_TC) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_short     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            PRESS2: begin
                if (!db_level) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            HELD: begin
                if (!db_level) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == REPEAT_TC) begin
                    w_cnt_nxt = '0;
                    w_repeat  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign short_tick  = r_short;
    assign double_tick = r_double;
    assign long_tick   = r_long;
    assign repeat_tick = r_repeat;
    assign busy        = r_busy;

endmodule
